// File: rtl/multi_alarm_ctrl_if.sv
// Keypad/button inputs and datapath control outputs of the multi-alarm clock controller.
// The master modport drives the inputs; the slave modport is the controller side.
interface multi_alarm_ctrl_if #(
  parameter int NUM_ALARMS = 4
);
  localparam int SEL_W = $clog2(NUM_ALARMS);

  logic             one_second;
  logic [3:0]       key;
  logic             alarm_button;
  logic             time_button;
  logic             next_button;

  logic             shift;
  logic             show_new_time;
  logic             show_a;
  logic             load_new_a;
  logic             load_new_c;
  logic             reset_count;
  logic [SEL_W-1:0] alarm_sel;
  logic [3:0]       digit_count;
  logic             entry_abort;

  modport master (
    output one_second, key, alarm_button, time_button, next_button,
    input  shift, show_new_time, show_a, load_new_a, load_new_c, reset_count,
           alarm_sel, digit_count, entry_abort
  );

  modport slave (
    input  one_second, key, alarm_button, time_button, next_button,
    output shift, show_new_time, show_a, load_new_a, load_new_c, reset_count,
           alarm_sel, digit_count, entry_abort
  );
endinterface

// File: rtl/multi_alarm_ctrl.sv
// Moore keypad-entry controller for a multi-alarm clock: digit entry, alarm/time load, inactivity timeout.
// Optional ENTRY_CANCEL_EN: key code 11 during an entry abandons it immediately.
module multi_alarm_ctrl #(
  parameter int         NUM_ALARMS  = 4,
  parameter int         NUM_DIGITS  = 4,
  parameter int         TIMEOUT_SEC = 10,
  parameter logic [3:0] NOT_PRESSED = 4'd10
) (
  input logic               clock,
  input logic               reset,
  multi_alarm_ctrl_if.slave bus
);
  localparam int               SEL_W       = $clog2(NUM_ALARMS);
  localparam logic [3:0]       MAX_DIGITS  = 4'(NUM_DIGITS);
  localparam logic [3:0]       TIMEOUT_LIM = 4'(TIMEOUT_SEC);
  localparam logic [SEL_W-1:0] LAST_SEL    = SEL_W'(NUM_ALARMS - 1);

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    KEY_STORED       = 3'd1,
    KEY_WAITED       = 3'd2,
    KEY_ENTRY        = 3'd3,
    SHOW_ALARM       = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       digit_count_q, digit_count_d;
  logic [3:0]       timeout_q, timeout_d;
  logic [SEL_W-1:0] alarm_sel_q, alarm_sel_d;
  logic             entry_abort_q, entry_abort_d;

  logic key_pressed;
  logic time_out;
  logic in_entry;
  logic cancel_key;

  assign key_pressed = (bus.key != NOT_PRESSED);
  assign time_out    = (timeout_q == TIMEOUT_LIM);
  assign in_entry    = (state_q == KEY_WAITED) || (state_q == KEY_ENTRY);

`ifdef ENTRY_CANCEL_EN
  localparam logic [3:0] CANCEL_KEY = 4'd11;
  assign cancel_key = (bus.key == CANCEL_KEY);
`else
  assign cancel_key = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= SHOW_TIME;
    else       state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d       = state_q;
    entry_abort_d = 1'b0;
    case (state_q)
      SHOW_TIME: begin
        if (bus.alarm_button)              state_d = SHOW_ALARM;
        else if (key_pressed && !cancel_key) state_d = KEY_STORED;
      end
      KEY_STORED: state_d = KEY_WAITED;
      KEY_WAITED: begin
        if (cancel_key) begin
          state_d       = SHOW_TIME;
          entry_abort_d = 1'b1;
        end else if (!key_pressed) begin
          state_d = KEY_ENTRY;
        end else if (time_out) begin
          state_d       = SHOW_TIME;
          entry_abort_d = 1'b1;
        end
      end
      KEY_ENTRY: begin
        if (cancel_key) begin
          state_d       = SHOW_TIME;
          entry_abort_d = 1'b1;
        end else if (bus.alarm_button) begin
          state_d = SET_ALARM_TIME;
        end else if (bus.time_button) begin
          state_d = SET_CURRENT_TIME;
        end else if (time_out) begin
          state_d       = SHOW_TIME;
          entry_abort_d = 1'b1;
        end else if (key_pressed && (digit_count_q < MAX_DIGITS)) begin
          state_d = KEY_STORED;
        end
      end
      SHOW_ALARM: begin
        if (!bus.alarm_button) state_d = SHOW_TIME;
      end
      SET_ALARM_TIME, SET_CURRENT_TIME: state_d = SHOW_TIME;
      default: state_d = SHOW_TIME;
    endcase
  end

  always_comb begin
    bus.shift         = 1'b0;
    bus.show_new_time = 1'b0;
    bus.show_a        = 1'b0;
    bus.load_new_a    = 1'b0;
    bus.load_new_c    = 1'b0;
    bus.reset_count   = 1'b0;
    case (state_q)
      KEY_STORED: begin
        bus.shift         = 1'b1;
        bus.show_new_time = 1'b1;
      end
      KEY_WAITED, KEY_ENTRY: bus.show_new_time = 1'b1;
      SHOW_ALARM:            bus.show_a        = 1'b1;
      SET_ALARM_TIME:        bus.load_new_a    = 1'b1;
      SET_CURRENT_TIME: begin
        bus.load_new_c  = 1'b1;
        bus.reset_count = 1'b1;
      end
      default: ;
    endcase
  end

  // Clearing on the way into SHOW_TIME keeps digit_count at zero for the whole time the state is SHOW_TIME.
  always_comb begin
    digit_count_d = digit_count_q;
    if (state_d == SHOW_TIME)       digit_count_d = '0;
    else if (state_q == KEY_STORED) digit_count_d = digit_count_q + 4'd1;

    timeout_d = timeout_q;
    if (!in_entry)                     timeout_d = '0;
    else if (bus.one_second && !time_out) timeout_d = timeout_q + 4'd1;

    alarm_sel_d = alarm_sel_q;
    if ((state_q == SHOW_ALARM) && bus.next_button)
      alarm_sel_d = (alarm_sel_q == LAST_SEL) ? '0 : alarm_sel_q + SEL_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digit_count_q <= '0;
      timeout_q     <= '0;
      alarm_sel_q   <= '0;
      entry_abort_q <= 1'b0;
    end else begin
      digit_count_q <= digit_count_d;
      timeout_q     <= timeout_d;
      alarm_sel_q   <= alarm_sel_d;
      entry_abort_q <= entry_abort_d;
    end
  end

  assign bus.alarm_sel   = alarm_sel_q;
  assign bus.digit_count = digit_count_q;
  assign bus.entry_abort = entry_abort_q;
endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Bench for multi_alarm_ctrl: vector table, directed corner sequences, and random traffic
// checked against a keypad-behaviour model. Honours ENTRY_CANCEL_EN when defined.
`timescale 1ns/1ps
module tb_multi_alarm_ctrl;
  localparam int         NA = 4;
  localparam int         ND = 4;
  localparam int         TO = 10;
  localparam logic [3:0] NP = 4'd10;

  logic clock = 1'b0;
  logic reset = 1'b1;

  multi_alarm_ctrl_if #(.NUM_ALARMS(NA)) bus ();

  multi_alarm_ctrl #(
    .NUM_ALARMS (NA),
    .NUM_DIGITS (ND),
    .TIMEOUT_SEC(TO),
    .NOT_PRESSED(NP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack(input bit sh, input bit snt, input bit sa, input bit la,
                                       input bit lc, input bit rc, input bit ab,
                                       input int sel, input int cnt);
    return {17'd0, ab, rc, lc, la, sa, snt, sh, 4'(sel), 4'(cnt)};
  endfunction

  function automatic logic [31:0] outs();
    return {17'd0, bus.entry_abort, bus.reset_count, bus.load_new_c, bus.load_new_a,
            bus.show_a, bus.show_new_time, bus.shift, 4'(bus.alarm_sel), bus.digit_count};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.one_second   = 1'b0;
    bus.key          = NP;
    bus.alarm_button = 1'b0;
    bus.time_button  = 1'b0;
    bus.next_button  = 1'b0;
  endtask

  task automatic enter_digit(input logic [3:0] d, inout int shifts);
    bus.key = d;  tick(); shifts += int'(bus.shift);
    bus.key = NP; tick(); shifts += int'(bus.shift);
    tick();               shifts += int'(bus.shift);
  endtask

  // Behavioural model: an entry is a sequence of store pulses, each needing the key released
  // before the next digit; inactivity seconds accumulate only while waiting inside an entry.
  bit m_entering, m_storing, m_released, m_viewing, m_load_a, m_load_c, m_abort;
  int m_digits, m_secs, m_sel;

  task automatic model_reset();
    m_entering = 0; m_storing = 0; m_released = 0; m_viewing = 0;
    m_load_a = 0; m_load_c = 0; m_abort = 0;
    m_digits = 0; m_secs = 0; m_sel = 0;
  endtask

  task automatic model_step(input logic [3:0] k, input bit al, input bit tb, input bit nx, input bit os);
    bit expired;
    bit cancel;
    bit waiting;
    expired = (m_secs == TO);
    cancel  = 0;
`ifdef ENTRY_CANCEL_EN
    cancel  = (k == 4'd11);
`endif
    waiting = m_entering && !m_storing;
    m_abort = 0;
    if (waiting) begin
      if (os && m_secs < TO) m_secs++;
    end else begin
      m_secs = 0;
    end

    if (m_load_a || m_load_c) begin
      m_load_a = 0;
      m_load_c = 0;
    end else if (m_viewing) begin
      if (nx) m_sel = (m_sel + 1) % NA;
      if (!al) m_viewing = 0;
    end else if (!m_entering) begin
      if (al) m_viewing = 1;
      else if (k != NP && !cancel) begin
        m_entering = 1;
        m_storing  = 1;
      end
    end else if (m_storing) begin
      m_storing  = 0;
      m_released = 0;
      m_digits++;
    end else if (cancel) begin
      m_entering = 0;
      m_abort    = 1;
    end else if (!m_released) begin
      if (k == NP) m_released = 1;
      else if (expired) begin
        m_entering = 0;
        m_abort    = 1;
      end
    end else begin
      if (al) begin
        m_entering = 0;
        m_load_a   = 1;
      end else if (tb) begin
        m_entering = 0;
        m_load_c   = 1;
      end else if (expired) begin
        m_entering = 0;
        m_abort    = 1;
      end else if (k != NP && m_digits < ND) begin
        m_storing = 1;
      end
    end

    if (!m_entering && !m_viewing && !m_load_a && !m_load_c) m_digits = 0;
  endtask

  function automatic logic [31:0] model_outs();
    return pack(m_storing, m_entering, m_viewing, m_load_a, m_load_c, m_load_c, m_abort, m_sel, m_digits);
  endfunction

  typedef struct {
    logic [3:0] key;
    logic       alarm;
    logic       tbtn;
    logic       shift;
    logic       snt;
    logic       la;
    logic       lc;
    int         cnt;
  } vec_t;

  task automatic run_table();
    vec_t vecs[$];
    for (int d = 1; d <= 4; d++) begin
      vecs.push_back('{key: 4'(d), alarm: 0, tbtn: 0, shift: 1, snt: 1, la: 0, lc: 0, cnt: d - 1});
      vecs.push_back('{key: NP,    alarm: 0, tbtn: 0, shift: 0, snt: 1, la: 0, lc: 0, cnt: d});
      vecs.push_back('{key: NP,    alarm: 0, tbtn: 0, shift: 0, snt: 1, la: 0, lc: 0, cnt: d});
    end
    // Fifth digit is ignored once the entry is full, then time_button loads the clock.
    vecs.push_back('{key: 4'd5, alarm: 0, tbtn: 0, shift: 0, snt: 1, la: 0, lc: 0, cnt: 4});
    vecs.push_back('{key: NP,   alarm: 0, tbtn: 0, shift: 0, snt: 1, la: 0, lc: 0, cnt: 4});
    vecs.push_back('{key: NP,   alarm: 0, tbtn: 1, shift: 0, snt: 0, la: 0, lc: 1, cnt: 4});
    vecs.push_back('{key: NP,   alarm: 0, tbtn: 0, shift: 0, snt: 0, la: 0, lc: 0, cnt: 0});
    vecs.push_back('{key: NP,   alarm: 0, tbtn: 0, shift: 0, snt: 0, la: 0, lc: 0, cnt: 0});
    foreach (vecs[i]) begin
      bus.key          = vecs[i].key;
      bus.alarm_button = vecs[i].alarm;
      bus.time_button  = vecs[i].tbtn;
      tick();
      check($sformatf("vec%0d", i), outs(),
            pack(vecs[i].shift, vecs[i].snt, 0, vecs[i].la, vecs[i].lc, vecs[i].lc, 0, 0, vecs[i].cnt));
    end
    idle_inputs();
  endtask

  task automatic run_random();
    logic [3:0] k;
    bit al, tb, nx, os, sparse;
    al = 0;
    reset = 1'b1; idle_inputs(); tick(); reset = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      sparse = ((c / 200) % 2) == 1;
      if (sparse) k = ($urandom_range(0, 99) < 4)  ? 4'($urandom_range(0, 11)) : NP;
      else        k = ($urandom_range(0, 99) < 45) ? 4'($urandom_range(0, 11)) : NP;
      os = sparse ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) al = !al;
      tb = ($urandom_range(0, 29) == 0);
      nx = ($urandom_range(0, 3) == 0);
      bus.key = k; bus.alarm_button = al; bus.time_button = tb;
      bus.next_button = nx; bus.one_second = os;
      tick();
      model_step(k, al, tb, nx, os);
      check($sformatf("rand%0d", c), outs(), model_outs());
    end
    idle_inputs();
  endtask

  initial begin
    int shifts;
    bit seen;
    bit early;
    idle_inputs();
    reset = 1'b1;
    #1;
    check("reset_async", outs(), 32'd0);
    tick(); tick();
    check("reset_held", outs(), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_after_reset", outs(), 32'd0);

    run_table();

    // Four digits then alarm_button: one load_new_a clock on slot 0, then back to SHOW_TIME.
    shifts = 0;
    for (int d = 1; d <= 4; d++) enter_digit(4'(d), shifts);
    check("alarm_entry_shifts", 32'(shifts), 32'd4);
    check("alarm_entry_count", 32'(bus.digit_count), 32'd4);
    bus.alarm_button = 1'b1; tick();
    check("load_a_pulse", outs(), pack(0, 0, 0, 1, 0, 0, 0, 0, 4));
    bus.alarm_button = 1'b0; tick();
    check("load_a_done", outs(), 32'd0);

    // Single digit then ten seconds of silence abandons the entry.
    bus.key = 4'd7; tick(); bus.key = NP; tick(); tick();
    early = 0;
    for (int s = 0; s < TO - 1; s++) begin
      bus.one_second = 1'b1; tick(); early |= bus.entry_abort;
      bus.one_second = 1'b0; tick(); early |= bus.entry_abort;
    end
    check("no_early_abort", {31'd0, early}, 32'd0);
    check("still_in_entry", outs(), pack(0, 1, 0, 0, 0, 0, 0, 0, 1));
    bus.one_second = 1'b1; tick(); bus.one_second = 1'b0;
    seen = 0;
    for (int c = 0; c < 5 && !seen; c++) begin
      tick();
      if (bus.entry_abort === 1'b1) seen = 1;
    end
    check("timeout_abort_seen", {31'd0, seen}, 32'd1);
    check("timeout_show_time", outs(), pack(0, 0, 0, 0, 0, 0, 1, 0, 0));
    tick();
    check("abort_one_clock", outs(), 32'd0);

    // Alarm slot walk with wrap.
    bus.alarm_button = 1'b1; tick();
    check("show_alarm", outs(), pack(0, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int p = 0; p < 5; p++) begin
      bus.next_button = 1'b1; tick(); bus.next_button = 1'b0;
      check($sformatf("sel_step%0d", p), outs(), pack(0, 0, 1, 0, 0, 0, 0, (p + 1) % NA, 0));
      tick();
      check($sformatf("sel_hold%0d", p), outs(), pack(0, 0, 1, 0, 0, 0, 0, (p + 1) % NA, 0));
    end
    bus.alarm_button = 1'b0; tick();
    bus.next_button = 1'b1; tick(); bus.next_button = 1'b0;
    check("sel_holds_outside", outs(), pack(0, 0, 0, 0, 0, 0, 0, 1, 0));

    // Asynchronous reset in the middle of an entry.
    shifts = 0;
    enter_digit(4'd3, shifts);
    check("pre_reset_entry", outs(), pack(0, 1, 0, 0, 0, 0, 0, 1, 1));
    #2 reset = 1'b1;
    #1 check("reset_mid_entry", outs(), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("after_mid_reset", outs(), 32'd0);

`ifdef ENTRY_CANCEL_EN
    enter_digit(4'd8, shifts);
    bus.key = 4'd11; tick(); bus.key = NP;
    check("cancel_abort", outs(), pack(0, 0, 0, 0, 0, 0, 1, 0, 0));
    bus.key = 4'd11; tick(); tick(); bus.key = NP;
    check("cancel_ignored_idle", outs(), 32'd0);
`else
    bus.key = 4'd11; tick(); bus.key = NP;
    check("key11_is_digit", outs(), pack(1, 1, 0, 0, 0, 0, 0, 0, 0));
    tick();
    check("key11_stored", outs(), pack(0, 1, 0, 0, 0, 0, 0, 0, 1));
`endif

    run_random();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/multi_alarm_ctrl.md
MULTI_ALARM_CTRL -- requirements
Module: multi_alarm_ctrl

Interface
REQ-001 Parameter NUM_ALARMS, 4, number of alarm slots; legal range 2..16.
REQ-002 Parameter NUM_DIGITS, 4, maximum digits accepted per entry; legal range 1..8.
REQ-003 Parameter TIMEOUT_SEC, 10, seconds of inactivity before an entry is abandoned; legal range 1..15.
REQ-004 Parameter NOT_PRESSED, 4'd10, key code meaning no key is pressed.
REQ-005 clock  in  1  rising-edge system clock.
REQ-006 reset  in  1  reset, asynchronous, active-high.
REQ-007 one_second  in  1  one-clock pulse once per second.
REQ-008 key  in  4  keypad code; 0-9 are digits; NOT_PRESSED means idle.
REQ-009 alarm_button, time_button, next_button  in  1 each  level inputs; next_button is a one-clock pulse.
REQ-010 shift, show_new_time, show_a, load_new_a, load_new_c, reset_count  out  1 each  datapath controls.
REQ-011 alarm_sel  out  $clog2(NUM_ALARMS)  selected alarm slot.
REQ-012 digit_count  out  4  digits stored in the current entry.
REQ-013 entry_abort  out  1  one-clock pulse when an entry is abandoned.

Function
REQ-014 The block SHALL be a Moore FSM with states SHOW_TIME, KEY_STORED, KEY_WAITED, KEY_ENTRY, SHOW_ALARM, SET_ALARM_TIME and SET_CURRENT_TIME; unused encodings go to SHOW_TIME.
REQ-015 SHOW_TIME: alarm_button goes to SHOW_ALARM; otherwise key!=NOT_PRESSED goes to KEY_STORED; otherwise the FSM stays.
REQ-016 KEY_STORED goes to KEY_WAITED unconditionally; shift=1 and digit_count increments, in this state only.
REQ-017 KEY_WAITED: key==NOT_PRESSED goes to KEY_ENTRY; else time_out goes to SHOW_TIME; else the FSM stays.
REQ-018 KEY_ENTRY priority: alarm_button -> SET_ALARM_TIME; time_button -> SET_CURRENT_TIME; time_out -> SHOW_TIME; key!=NOT_PRESSED and digit_count<NUM_DIGITS -> KEY_STORED; otherwise stay.
REQ-019 When digit_count==NUM_DIGITS, key presses in KEY_ENTRY are ignored, with no shift and no count change.
REQ-020 SET_ALARM_TIME and SET_CURRENT_TIME SHALL each last one clock and then go to SHOW_TIME.
REQ-021 SHOW_ALARM returns to SHOW_TIME when alarm_button=0.
REQ-022 In SHOW_ALARM, next_button increments alarm_sel, wrapping from NUM_ALARMS-1 to 0; outside SHOW_ALARM, alarm_sel holds.
REQ-023 Timeout counter:
  - cleared in every state except KEY_WAITED and KEY_ENTRY, so it is cleared on each KEY_STORED;
  - increments on one_second and saturates at TIMEOUT_SEC;
  - time_out is 1 when count==TIMEOUT_SEC.
REQ-024 entry_abort SHALL pulse on the clock where KEY_WAITED or KEY_ENTRY transitions to SHOW_TIME because of time_out.
REQ-025 digit_count SHALL clear whenever the state is SHOW_TIME.
REQ-026 Output decodes:
  - show_new_time = KEY_STORED, KEY_WAITED or KEY_ENTRY;
  - show_a = SHOW_ALARM;
  - load_new_a = SET_ALARM_TIME, with alarm_sel stable;
  - load_new_c = reset_count = SET_CURRENT_TIME.

Reset
REQ-027 Reset SHALL force state SHOW_TIME, alarm_sel=0, digit_count=0, timeout count=0 and all 1-bit outputs 0, taking effect immediately, including mid-entry.

Configuration
REQ-028 With ENTRY_CANCEL_EN defined, key==4'd11 in KEY_WAITED or KEY_ENTRY has top priority, goes to SHOW_TIME and pulses entry_abort; code 11 in SHOW_TIME is ignored.
REQ-029 Without ENTRY_CANCEL_EN, code 11 is treated like any non-NOT_PRESSED key.

Verification
REQ-030 Keys 1,2,3,4, each released, then alarm_button -> 4 shift pulses, digit_count=4, then one load_new_a clock with alarm_sel=0, then SHOW_TIME.
REQ-031 After 4 digits (NUM_DIGITS=4), press key 5 -> no shift, digit_count stays 4; time_button -> load_new_c=reset_count=1 for one clock.
REQ-032 Key 7 released, then 10 one_second pulses with no input -> entry_abort pulse and SHOW_TIME; digit_count=0.
REQ-033 Hold alarm_button and give 5 next_button pulses (NUM_ALARMS=4) -> alarm_sel sequence 1,2,3,0,1; show_a=1 throughout.
REQ-034 Assert reset while in KEY_ENTRY -> state SHOW_TIME and all outputs 0 before the next clock edge.
REQ-035 With ENTRY_CANCEL_EN defined, key 11 pressed in KEY_ENTRY -> entry_abort pulse and SHOW_TIME.
